// File: rtl/and3_sweep_pkg.sv
// Shared types and limits for the 3-input AND sweep controller.
// The limits bound the settle time so the settle counter stays 4 bits wide.
package and3_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SAMPLE,
    DONE
  } sweep_state_e;

  localparam int NUM_VEC    = 8;
  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;
  localparam int SETTLE_W   = 4;

endpackage

// File: rtl/sweep_settle_timer.sv
// Settle counter: load arms it for SETTLE cycles, tick counts down,
// and expire flags the last cycle of the settle window.
module sweep_settle_timer
  import and3_sweep_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic tick,
  output logic expire
);

  logic [SETTLE_W-1:0] cnt_q, cnt_d;

  // Loaded with SETTLE-1 so expire is seen on exactly the SETTLE-th tick cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = SETTLE_W'(SETTLE - 1);
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/and3_sweep_ctrl.sv
// Exhaustive 8-vector sweep of an external 3-input AND datapath.
// All outputs come from flops; d_in/e_in only reach next-state logic.
module and3_sweep_ctrl
  import and3_sweep_pkg::*;
#(
  parameter int SETTLE       = 2,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  input  logic       d_in,
  input  logic       e_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_vec,
  output logic [2:0] vec_idx
);

  sweep_state_e state_q, state_d;
  logic [2:0]   vec_idx_q, vec_idx_d;
  logic [2:0]   drive_q, drive_d;
  logic [3:0]   err_count_q, err_count_d;
  logic [7:0]   fail_vec_q, fail_vec_d;
  logic         pass_q, pass_d;
  logic         settle_load;
  logic         settle_expire;
  logic         mismatch;

  sweep_settle_timer #(
    .SETTLE(SETTLE)
  ) u_settle (
    .clk   (clk),
    .rst   (rst),
    .load  (settle_load),
    .tick  (state_q == WAIT),
    .expire(settle_expire)
  );

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    vec_idx_d   = vec_idx_q;
    err_count_d = err_count_q;
    fail_vec_d  = fail_vec_q;
    pass_d      = pass_q;
    settle_load = 1'b0;
    mismatch    = (d_in != (drive_q[2] & drive_q[1])) || (e_in != (&drive_q));

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = WAIT;
          vec_idx_d   = '0;
          err_count_d = '0;
          fail_vec_d  = '0;
          pass_d      = 1'b0;
          settle_load = 1'b1;
        end
      end
      WAIT: begin
        if (settle_expire) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (mismatch) begin
          if (err_count_q != 4'(NUM_VEC)) err_count_d = err_count_q + 4'd1;
          fail_vec_d[vec_idx_q] = 1'b1;
        end
        if ((vec_idx_q == 3'(NUM_VEC - 1)) || (STOP_ON_FAIL && mismatch)) begin
          state_d = DONE;
          pass_d  = (err_count_d == '0);
        end else begin
          state_d     = WAIT;
          vec_idx_d   = vec_idx_q + 3'd1;
          settle_load = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Drive pattern is registered from next-state values so a/b/c switch cleanly together.
    drive_d = ((state_d == WAIT) || (state_d == SAMPLE)) ? vec_idx_d : 3'b000;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      vec_idx_q   <= '0;
      drive_q     <= '0;
      err_count_q <= '0;
      fail_vec_q  <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_idx_q   <= vec_idx_d;
      drive_q     <= drive_d;
      err_count_q <= err_count_d;
      fail_vec_q  <= fail_vec_d;
      pass_q      <= pass_d;
    end
  end

  assign a_out     = drive_q[2];
  assign b_out     = drive_q[1];
  assign c_out     = drive_q[0];
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign err_count = err_count_q;
  assign fail_vec  = fail_vec_q;
  assign vec_idx   = vec_idx_q;

endmodule
